pulse_generator: RTL and testbench

PULSE_GENERATOR -- requirements
Module: pulse_generator

---
 rtl/pulse_generator_pkg.sv | 14 +
 rtl/pulse_phase_timer.sv | 24 ++
 rtl/pulse_generator.sv | 113 +++++++++++
 tb/tb_pulse_generator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_generator_pkg.sv
// Shared definitions for the pulse generator: state encoding and default field widths.
package pulse_generator_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int PH_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_DONE = 2'd3
   } pg_state_e;

endpackage

// File: rtl/pulse_phase_timer.sv
// Phase-length down-counter: loaded at phase entry, counts to zero and parks there.
module pulse_phase_timer #(
   parameter int PH_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [PH_W-1:0] load_val,
   output logic [PH_W-1:0] value,
   output logic            expired
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (value != '0)
         value <= value - PH_W'(1);
   end

   assign expired = (value == '0);

endmodule

// File: rtl/pulse_generator.sv
// Burst pulse generator: emits load_count pulses of H cycles high separated by L cycles low.
module pulse_generator
   import pulse_generator_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PH_W  = PH_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [CNT_W-1:0] load_count,
   input  logic [PH_W-1:0]  high_cycles,
   input  logic [PH_W-1:0]  low_cycles,
   output logic             out_pulse,
   output logic [CNT_W-1:0] remaining,
   output logic             busy,
   output logic             done
);

   pg_state_e        state_q, state_d;
   logic [CNT_W-1:0] rem_d;
   logic [PH_W-1:0]  h_q, h_d, l_q, l_d;
   logic             tmr_load;
   logic [PH_W-1:0]  tmr_val;
   logic [PH_W-1:0]  tmr_value;
   logic             tmr_expired;

   function automatic logic [PH_W-1:0] at_least_one(input logic [PH_W-1:0] v);
      return (v == '0) ? PH_W'(1) : v;
   endfunction

   pulse_phase_timer #(.PH_W(PH_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .expired  (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      rem_d    = remaining;
      h_d      = h_q;
      l_d      = l_q;
      tmr_load = 1'b0;
      tmr_val  = h_q - PH_W'(1);
      // run low wins from any state: abort, reload fields, sit in IDLE
      if (!run) begin
         state_d = ST_IDLE;
         rem_d   = load_count;
         h_d     = at_least_one(high_cycles);
         l_d     = at_least_one(low_cycles);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (remaining != '0) begin
                  state_d  = ST_HIGH;
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
            ST_HIGH: begin
               if (tmr_expired) begin
                  if (remaining <= CNT_W'(1)) begin
                     state_d = ST_DONE;
                     rem_d   = '0;
                  end else begin
                     state_d  = ST_LOW;
                     rem_d    = remaining - CNT_W'(1);
                     tmr_load = 1'b1;
                     tmr_val  = l_q - PH_W'(1);
                  end
               end
            end
            ST_LOW: begin
               if (tmr_expired) begin
                  state_d  = ST_HIGH;
                  tmr_load = 1'b1;
               end
            end
            default: state_d = ST_DONE;
         endcase
      end
   end

   // outputs are decoded from the next state so they switch on the same edge as state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         remaining <= '0;
         h_q       <= PH_W'(1);
         l_q       <= PH_W'(1);
         out_pulse <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         remaining <= rem_d;
         h_q       <= h_d;
         l_q       <= l_d;
         out_pulse <= (state_d == ST_HIGH);
         busy      <= (state_d == ST_HIGH) || (state_d == ST_LOW);
         done      <= (state_d == ST_DONE);
      end
   end

   a_timer_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_HIGH || state_q == ST_LOW) |->
         tmr_value < ((state_q == ST_HIGH) ? h_q : l_q));

endmodule

// File: tb/tb_pulse_generator.sv
// Scoreboard bench for pulse_generator against an arithmetic burst-waveform model.
module tb_pulse_generator;
   localparam int CNT_W = 16;
   localparam int PH_W  = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             run = 1'b0;
   logic [CNT_W-1:0] load_count = '0;
   logic [PH_W-1:0]  high_cycles = '0;
   logic [PH_W-1:0]  low_cycles = '0;
   logic             out_pulse;
   logic [CNT_W-1:0] remaining;
   logic             busy;
   logic             done;

   pulse_generator #(.CNT_W(CNT_W), .PH_W(PH_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .load_count  (load_count),
      .high_cycles (high_cycles),
      .low_cycles  (low_cycles),
      .out_pulse   (out_pulse),
      .remaining   (remaining),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             o;
      logic             b;
      logic             d;
      logic [CNT_W-1:0] rem;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   edges = 0;
   logic prev_out = 1'b0;

   // model: latched burst parameters and count of consecutive run=1 edges
   int m_n = 0, m_h = 1, m_l = 1, m_k = 0;

   function automatic exp_t burst_exp(input int n, input int h, input int l, input int k);
      exp_t e;
      int   per, tot, idx, off;
      e = '0;
      if (n == 0) begin
         e.d = 1'b1;
      end else begin
         per = h + l;
         tot = n * per - l;
         if (k < tot) begin
            idx   = k / per;
            off   = k % per;
            e.b   = 1'b1;
            e.o   = (off < h);
            e.rem = CNT_W'(n - idx - ((off < h) ? 0 : 1));
         end else begin
            e.d = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (!run) begin
         m_n   = int'(load_count);
         m_h   = (high_cycles == 0) ? 1 : int'(high_cycles);
         m_l   = (low_cycles == 0) ? 1 : int'(low_cycles);
         m_k   = 0;
         e     = '0;
         e.rem = load_count;
      end else begin
         e   = burst_exp(m_n, m_h, m_l, m_k);
         m_k = m_k + 1;
      end
      q.push_back(e);
   endtask

   task automatic burst(input int n, input int h, input int l, input int run_len);
      load_count  = CNT_W'(n);
      high_cycles = PH_W'(h);
      low_cycles  = PH_W'(l);
      run = 1'b0;
      tick();
      tick();
      run = 1'b1;
      repeat (run_len) begin
         tick();
         load_count  = CNT_W'($urandom);
         high_cycles = PH_W'($urandom);
         low_cycles  = PH_W'($urandom);
      end
      run = 1'b0;
      load_count = CNT_W'($urandom_range(0, 9));
      tick();
   endtask

   function automatic int full_len(input int n, input int h, input int l);
      int he, le;
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      return (n == 0) ? 0 : n * (he + le) - le;
   endfunction

   task automatic check_reset(input string name);
      total++;
      if ({out_pulse, busy, done, remaining} !== '0) begin
         bad++;
         $display("FAIL %s: got out=%b busy=%b done=%b rem=%0d, want all zero",
                  name, out_pulse, busy, done, remaining);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_out = 1'b0;
      end else begin
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({out_pulse, busy, done, remaining} !== e) begin
               bad++;
               $display("FAIL cycle %0t: got out=%b busy=%b done=%b rem=%0d, want out=%b busy=%b done=%b rem=%0d",
                        $time, out_pulse, busy, done, remaining, e.o, e.b, e.d, e.rem);
            end
         end
         if (out_pulse && !prev_out) edges++;
         prev_out = out_pulse;
      end
   end

   initial begin
      int e0, n, h, l;
      #12;
      check_reset("reset_state");
      @(negedge clk);
      #1 rst_n = 1'b1;

      burst(3, 2, 1, full_len(3, 2, 1) + 3);     // 1,1,0,1,1,0,1,1 then done
      burst(0, 2, 2, 4);                          // empty burst goes straight to done
      burst(2, 0, 0, full_len(2, 0, 0) + 2);     // zero widths act as 1
      burst(5, 3, 2, 7);                          // abort during second HIGH
      burst(1, 1, 5, full_len(1, 1, 5) + 2);     // single pulse, no trailing LOW

      e0 = edges;
      burst(100, 3, 4, full_len(100, 3, 4) + 3);
      @(negedge clk);
      #1;
      total++;
      if (edges - e0 != 100) begin
         bad++;
         $display("FAIL loopback_edges: got %0d, want 100", edges - e0);
      end

      // reset while in the LOW phase, then a fresh burst
      load_count = 16'd4; high_cycles = 8'd2; low_cycles = 8'd3; run = 1'b0;
      tick(); tick();
      run = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      #1 rst_n = 1'b0;
      run = 1'b0;
      #1 check_reset("async_reset_mid_low");
      @(posedge clk);
      @(negedge clk);
      check_reset("reset_held");
      #1 rst_n = 1'b1;
      burst(4, 2, 3, full_len(4, 2, 3) + 2);

      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 6);
         h = $urandom_range(0, 4);
         l = $urandom_range(0, 4);
         burst(n, h, l, $urandom_range(1, full_len(n, h, l) + 3));
      end

      repeat (2) @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
